ram_stream_reader: RTL and testbench

Streaming read front-end for the IDDMM operand/result RAMs (`simple_ram`, 1-cycle registered read). On `start`, it walks `len` consecutive addresses from `base` and drives the RAM read port. It buffers the returned `q` words in a 4-entry FIFO and presents them on a valid/ready stream with `m_last` on the final word. It sits directly downstream of the RAM and feeds the result unloader and the bus read-back path.

---
 rtl/ram_stream_reader.sv | 177 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
//   Streaming read front-end for a 1-cycle registered-read RAM. On start it
//   walks len consecutive addresses from base (wrapping modulo 2^WIDTHAD),
//   buffers returned words in a 4-entry FIFO and presents them on a
//   valid/ready stream with m_last on the final word.
// Ports
//   clk, rst_n          clock, async active-low reset
//   start, base, len    launch a transfer (sampled in IDLE); len=0 -> 2^WIDTHAD
//   clear               synchronous abort, flushes everything in flight
//   rdaddress, q        RAM read port (address registered here, q one cycle later)
//   m_valid/m_ready     output stream handshake, m_data/m_last payload
//   busy, done          transfer in progress / one-cycle completion pulse
module ram_stream_reader #(
  parameter int WIDTH   = 64,
  parameter int WIDTHAD = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               clear,
  input  logic [WIDTHAD-1:0] base,
  input  logic [WIDTHAD-1:0] len,
  output logic [WIDTHAD-1:0] rdaddress,
  input  logic [WIDTH-1:0]   q,
  output logic               m_valid,
  output logic [WIDTH-1:0]   m_data,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } ent_t;

  localparam logic [WIDTHAD:0]   REM_ONE  = (WIDTHAD+1)'(1);
  localparam logic [WIDTHAD-1:0] ADDR_ONE = WIDTHAD'(1);

  state_e             state_q, state_d;
  logic [WIDTHAD-1:0] issue_addr_q, issue_addr_d;
  logic [WIDTHAD:0]   remain_q, remain_d;
  logic [WIDTHAD-1:0] rdaddress_q, rdaddress_d;
  // vld_pipe[0]: read issued last edge (RAM samples next edge);
  // vld_pipe[1]: q is valid now and gets pushed on this edge.
  logic [1:0]         vld_pipe_q, vld_pipe_d;
  logic [1:0]         last_pipe_q, last_pipe_d;
  ent_t               fifo_q [4];
  ent_t               fifo_d [4];
  logic [1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [2:0]         count_q, count_d;
  logic               done_q, done_d;

  logic [2:0]         outstanding;
  logic               credit, push, pop, issue, issue_last;
  logic [WIDTHAD-1:0] issue_at;
  logic [WIDTHAD:0]   start_len;
  ent_t               head;

  assign head        = fifo_q[rd_ptr_q];
  assign outstanding = {2'b0, vld_pipe_q[0]} + {2'b0, vld_pipe_q[1]};
  // Reads still in flight are pre-charged against FIFO space so a push can
  // never find the FIFO full.
  assign credit      = (count_q + outstanding) < 3'd4;
  assign push        = vld_pipe_q[1];
  assign pop         = (count_q != 3'd0) && m_ready;
  // len=0 encodes the full address space: the zero-test supplies the MSB.
  assign start_len   = {(len == '0), len};

  always_comb begin
    state_d      = state_q;
    issue_addr_d = issue_addr_q;
    remain_d     = remain_q;
    rdaddress_d  = rdaddress_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_d       = fifo_q;
    done_d       = 1'b0;
    issue        = 1'b0;
    issue_last   = 1'b0;
    issue_at     = issue_addr_q;

    case (state_q)
      IDLE: begin
        // The start edge itself issues the first read.
        if (start) begin
          issue        = 1'b1;
          issue_at     = base;
          issue_last   = (start_len == REM_ONE);
          issue_addr_d = base + ADDR_ONE;
          remain_d     = start_len - REM_ONE;
          state_d      = issue_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (credit) begin
          issue        = 1'b1;
          issue_last   = (remain_q == REM_ONE);
          issue_addr_d = issue_addr_q + ADDR_ONE;
          remain_d     = remain_q - REM_ONE;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && head.last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (issue) rdaddress_d = issue_at;
    vld_pipe_d  = {vld_pipe_q[0], issue};
    last_pipe_d = {last_pipe_q[0], issue_last};

    if (push) begin
      fifo_d[wr_ptr_q] = '{data: q, last: last_pipe_q[1]};
      wr_ptr_d         = wr_ptr_q + 2'd1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 2'd1;
    count_d = count_q + {2'b0, push} - {2'b0, pop};

    // Abort overrides everything above, including a same-cycle start.
    if (clear) begin
      state_d     = IDLE;
      rdaddress_d = rdaddress_q;
      vld_pipe_d  = '0;
      last_pipe_d = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      issue_addr_q <= '0;
      remain_q     <= '0;
      rdaddress_q  <= '0;
      vld_pipe_q   <= '0;
      last_pipe_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      done_q       <= 1'b0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      issue_addr_q <= issue_addr_d;
      remain_q     <= remain_d;
      rdaddress_q  <= rdaddress_d;
      vld_pipe_q   <= vld_pipe_d;
      last_pipe_q  <= last_pipe_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      done_q       <= done_d;
      for (int i = 0; i < 4; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  assign rdaddress = rdaddress_q;
  assign m_valid   = (count_q != 3'd0);
  assign m_data    = head.data;
  // Gated so a stale head entry after a flush never shows m_last.
  assign m_last    = m_valid && head.last;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: a simple_ram model feeds q; expected streams
// are built from mem[(base+k) mod 32] and compared word by word.
module tb_ram_stream_reader;
  localparam int W  = 64;
  localparam int AW = 5;
  localparam int N  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, clear = 1'b0, m_ready = 1'b0;
  logic [AW-1:0] base = '0, len = '0;
  logic [AW-1:0] rdaddress;
  logic [W-1:0]  q, m_data;
  logic          m_valid, m_last, busy, done;

  logic [W-1:0]  mem [N];
  int            n_chk = 0, n_pass = 0, ovf_err = 0;

  ram_stream_reader #(.WIDTH(W), .WIDTHAD(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear), .base(base),
    .len(len), .rdaddress(rdaddress), .q(q), .m_valid(m_valid),
    .m_data(m_data), .m_last(m_last), .m_ready(m_ready), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  // simple_ram read port: registered read
  always @(posedge clk) q <= mem[rdaddress];

  always @(negedge clk)
    if (dut.count_q > 3'd4) begin
      ovf_err++;
      $display("FAIL fifo_ovf count=%0d required<=4", dut.count_q);
    end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] mw(input int b, input int k);
    return mem[(b + k) % N];
  endfunction

  // leaves the bench 1ns into cycle 1 (start was held through cycle 0)
  task automatic do_start(input int b, input int l);
    @(posedge clk); #1;
    start = 1'b1; base = AW'(b); len = AW'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // cycle-exact check with m_ready=1; optional stray start during RUN
  task automatic run_timed(input int b, input int l, input bit noise);
    int n;
    n = (l == 0) ? N : l;
    m_ready = 1'b1;
    do_start(b, l);
    for (int c = 1; c <= n + 4; c++) begin
      @(negedge clk);
      if (c == 1) chk("rdaddr_c1", rdaddress, b);
      chk($sformatf("busy_c%0d", c), busy, (c <= n + 2));
      chk($sformatf("valid_c%0d", c), m_valid, (c >= 3 && c <= n + 2));
      if (c >= 3 && c <= n + 2) begin
        chk($sformatf("data_c%0d", c), m_data, mw(b, c - 3));
        chk($sformatf("last_c%0d", c), m_last, (c == n + 2));
      end
      chk($sformatf("done_c%0d", c), done, (c == n + 3));
      @(posedge clk); #1;
      if (noise && c == 1) begin
        start = 1'b1; base = AW'(b + 7); len = AW'(1);
      end else start = 1'b0;
    end
  endtask

  // collect n words under random m_ready, compare with reference queue
  task automatic collect(input int b, input int n, input int pct);
    logic [W-1:0] exp_q[$];
    int got = 0, dones = 0, lasts = 0, after = 0, budget = 3000;
    bit stall = 0;
    logic [W-1:0] prev = '0;
    for (int k = 0; k < n; k++) exp_q.push_back(mw(b, k));
    while (budget > 0 && !(got >= n && after >= 4)) begin
      budget--;
      m_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      if (done) dones++;
      if (stall && m_valid) chk("hold", m_data, prev);
      if (m_valid && m_ready) begin
        if (got < n) begin
          chk($sformatf("word%0d", got), m_data, exp_q[got]);
          chk($sformatf("last%0d", got), m_last, (got == n - 1));
        end
        if (m_last) lasts++;
        got++;
      end
      stall = m_valid && !m_ready;
      prev  = m_data;
      if (got >= n) after++;
      @(posedge clk); #1;
    end
    chk("budget", (budget > 0), 1);
    chk("n_words", got, n);
    chk("n_last", lasts, 1);
    chk("n_done", dones, 1);
    chk("busy_end", busy, 0);
    m_ready = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] = W'(i);

    // reset state
    #2;
    chk("rst_rdaddr", rdaddress, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #20 rst_n = 1'b1;

    // basic, wrap, full space
    run_timed(3, 4, 0);
    run_timed(30, 3, 0);
    run_timed(5, 1, 0);
    do_start(0, 0);
    collect(0, N, 100);

    // backpressure: m_ready held low through cycle 10
    m_ready = 1'b0;
    do_start(0, 8);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) begin
        chk("bp_valid", m_valid, 1);
        chk("bp_data", m_data, 0);
        chk("bp_fifo", dut.count_q, 4);
        chk("bp_outst", dut.vld_pipe_q, 0);
        chk("bp_rdaddr", rdaddress, 3);
      end
      @(posedge clk); #1;
    end
    collect(0, 8, 100);

    // random backpressure with random contents
    for (int i = 0; i < N; i++) mem[i] = {$urandom, $urandom};
    for (int t = 0; t < 4; t++) begin
      int b;
      b = $urandom_range(N - 1);
      do_start(b, 16);
      collect(b, 16, 50);
    end
    for (int i = 0; i < N; i++) mem[i] = W'(i);

    // clear in cycle 5 of a len=10 transfer, restart in cycle 6
    m_ready = 1'b1;
    do_start(0, 10);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c >= 3 && c <= 5) chk($sformatf("clr_pre_c%0d", c), m_data, c - 3);
      if (c >= 6 && c <= 8) begin
        chk($sformatf("clr_valid_c%0d", c), m_valid, 0);
        chk($sformatf("clr_done_c%0d", c), done, 0);
      end
      if (c == 6) chk("clr_busy", busy, 0);
      if (c == 9 || c == 10) begin
        chk($sformatf("rs_valid_c%0d", c), m_valid, 1);
        chk($sformatf("rs_data_c%0d", c), m_data, 20 + c - 9);
        chk($sformatf("rs_last_c%0d", c), m_last, (c == 10));
      end
      if (c == 11) chk("rs_done", done, 1);
      if (c == 12) chk("rs_idle", m_valid, 0);
      @(posedge clk); #1;
      clear = (c == 4);
      if (c == 5) begin start = 1'b1; base = AW'(20); len = AW'(2); end
      else start = 1'b0;
    end

    // async reset mid-RUN
    do_start(0, 16);
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_rdaddr", rdaddress, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_data", m_data, 0);
    chk("arst_last", m_last, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    #13 rst_n = 1'b1;
    run_timed(3, 4, 0);
    run_timed(3, 4, 1);

    chk("fifo_ovf", ovf_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=hang exp=finish");
    $fatal(1, "timeout");
  end
endmodule
